// File: rtl/pc_fetch_unit.sv
// Program counter and fetch sequencer: boot slot, sequential fetch, taken-branch bubble, halt.
// Optional taken-branch counter output enabled by PC_FETCH_BRANCH_COUNT_EN.
module pc_fetch_unit #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  PCsrc,
  input  logic [DATA_WIDTH-1:0] ImmOp,
  input  logic                  stall,
  output logic [DATA_WIDTH-1:0] PC,
  output logic                  pc_valid,
  output logic                  halted,
  output logic                  misaligned
`ifdef PC_FETCH_BRANCH_COUNT_EN
  ,
  output logic [31:0]           branch_count
`endif
);

  typedef enum logic [1:0] {BOOT, RUN, BUBBLE, HALT} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic                  mis_q, mis_d;
  logic [DATA_WIDTH-1:0] target;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    mis_d   = mis_q;
    target  = pc_q + ImmOp;
    case (state_q)
      BOOT:   state_d = RUN;
      RUN: begin
        // stall outranks any branch decision for the current slot
        if (!stall) begin
          if (!PCsrc) begin
            pc_d = pc_q + DATA_WIDTH'(4);
          end else if (target[1:0] != 2'b00) begin
            mis_d   = 1'b1;
            state_d = HALT;
          end else if (ImmOp == '0) begin
            state_d = HALT;
          end else begin
            pc_d    = target;
            state_d = BUBBLE;
          end
        end
      end
      BUBBLE: state_d = RUN;
      HALT:   state_d = HALT;
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      mis_q   <= mis_d;
    end
  end

  // Outputs come straight from flops / state decode so no input reaches them combinationally.
  assign PC         = pc_q;
  assign pc_valid   = (state_q == RUN);
  assign halted     = (state_q == HALT);
  assign misaligned = mis_q;

`ifdef PC_FETCH_BRANCH_COUNT_EN
  logic [31:0] cnt_q, cnt_d;

  // BUBBLE is entered only from a loaded taken branch.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == RUN && state_d == BUBBLE) cnt_d = cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign branch_count = cnt_q;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios plus randomized run
// against a slot-level behavioural model.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        PCsrc = 1'b0;
  logic        stall = 1'b0;
  logic [31:0] ImmOp = '0;
  logic        zero_b = 1'b0;
  logic [31:0] zero_w = '0;

  logic [31:0] pc0, pc1;
  logic        pv0, pv1, h0, h1, m0, m1;
`ifdef PC_FETCH_BRANCH_COUNT_EN
  logic [31:0] bc0, bc1;
`endif

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // model: current slot address, whether slot is real, halted, sticky flag, branch count
  logic [31:0] m_pc, m_cnt;
  bit          m_valid, m_halted, m_mis;

  always #5 clk = ~clk;

  pc_fetch_unit u0 (
    .clk(clk), .rst_n(rst_n), .PCsrc(PCsrc), .ImmOp(ImmOp), .stall(stall),
    .PC(pc0), .pc_valid(pv0), .halted(h0), .misaligned(m0)
`ifdef PC_FETCH_BRANCH_COUNT_EN
    , .branch_count(bc0)
`endif
  );

  pc_fetch_unit #(.DATA_WIDTH(32), .RESET_PC(32'hFFFF_FFF8)) u1 (
    .clk(clk), .rst_n(rst_n), .PCsrc(zero_b), .ImmOp(zero_w), .stall(zero_b),
    .PC(pc1), .pc_valid(pv1), .halted(h1), .misaligned(m1)
`ifdef PC_FETCH_BRANCH_COUNT_EN
    , .branch_count(bc1)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_valid = 1'b0; m_halted = 1'b0; m_mis = 1'b0; m_cnt = 32'h0;
  endtask

  task automatic model_step();
    logic [31:0] tgt;
    tgt = m_pc + ImmOp;
    if (m_halted) begin
      // nothing leaves halt except reset
    end else if (!m_valid) begin
      m_valid = 1'b1;
    end else if (stall) begin
      // slot repeats
    end else if (!PCsrc) begin
      m_pc = m_pc + 32'd4;
    end else if (tgt % 4 != 0) begin
      m_mis = 1'b1; m_halted = 1'b1; m_valid = 1'b0;
    end else if (ImmOp == 32'h0) begin
      m_halted = 1'b1; m_valid = 1'b0;
    end else begin
      m_pc = tgt; m_valid = 1'b0; m_cnt = m_cnt + 32'd1;
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc.pc", pc0, m_pc);
      chk("cyc.pc_valid", {31'b0, pv0}, {31'b0, m_valid});
      chk("cyc.halted", {31'b0, h0}, {31'b0, m_halted});
      chk("cyc.misaligned", {31'b0, m0}, {31'b0, m_mis});
`ifdef PC_FETCH_BRANCH_COUNT_EN
      chk("cyc.branch_count", bc0, m_cnt);
`endif
    end
  end

  // One slot: inputs apply to the slot currently shown, model advances on the edge.
  task automatic cyc(input bit src, input logic [31:0] imm, input bit stl);
    PCsrc = src; ImmOp = imm; stall = stl;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic rst_pulse();
    #($urandom_range(1, 3));
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic lit(input string tag, input logic [31:0] pc, input bit pv, input bit h, input bit m);
    chk({tag, ".pc"}, pc0, pc);
    chk({tag, ".pc_valid"}, {31'b0, pv0}, {31'b0, pv});
    chk({tag, ".halted"}, {31'b0, h0}, {31'b0, h});
    chk({tag, ".misaligned"}, {31'b0, m0}, {31'b0, m});
    chk({tag, ".model_pc"}, m_pc, pc);
  endtask

  initial begin
    logic [31:0] e0 [4];
    logic [31:0] e1 [4];
    logic [31:0] imm;
    int r;
    e0 = '{32'h0, 32'h4, 32'h8, 32'hC};
    e1 = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4};

    model_reset();
    chk_en = 1'b1;
    @(posedge clk);
    #1;
    lit("reset", 32'h0, 0, 0, 0);
    rst_n = 1'b1;

    // reset release, free run; second instance wraps past the top of memory
    lit("boot", 32'h0, 0, 0, 0);
    chk("wrap.boot_pc", pc1, 32'hFFFF_FFF8);
    chk("wrap.boot_valid", {31'b0, pv1}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 32'h0, 0);
      lit("seq", e0[i], 1, 0, 0);
      chk("wrap.pc", pc1, e1[i]);
      chk("wrap.flags", {29'b0, pv1, h1, m1}, 32'h4);
    end

    // backward branch from 8 to 0
    rst_pulse();
    repeat (3) cyc(0, 32'h0, 0);
    lit("pre_br", 32'h8, 1, 0, 0);
    cyc(1, 32'hFFFF_FFF8, 0);
    lit("br_bubble", 32'h0, 0, 0, 0);
`ifdef PC_FETCH_BRANCH_COUNT_EN
    chk("br_count", bc0, 32'd1);
`endif
    cyc(0, 32'h0, 0);
    lit("br_target", 32'h0, 1, 0, 0);
    cyc(0, 32'h0, 0);
    lit("br_next", 32'h4, 1, 0, 0);

    // stall outranks a pending branch
    repeat (3) cyc(0, 32'h0, 0);
    lit("pre_stall", 32'h10, 1, 0, 0);
    repeat (3) begin
      cyc(1, 32'h8, 1);
      lit("stall_hold", 32'h10, 1, 0, 0);
    end
    cyc(1, 32'h8, 0);
    lit("stall_br", 32'h18, 0, 0, 0);
    cyc(0, 32'h0, 0);
    lit("stall_after", 32'h18, 1, 0, 0);

    // branch to self halts until reset
    rst_pulse();
    lit("rst2", 32'h0, 0, 0, 0);
    repeat (4) cyc(0, 32'h0, 0);
    lit("pre_self", 32'hC, 1, 0, 0);
    cyc(1, 32'h0, 0);
    lit("self_halt", 32'hC, 0, 1, 0);
    repeat (5) begin
      cyc(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
      lit("halt_hold", 32'hC, 0, 1, 0);
    end
    rst_pulse();
    lit("halt_rst", 32'h0, 0, 0, 0);

    // misaligned target
    repeat (2) cyc(0, 32'h0, 0);
    lit("pre_mis", 32'h4, 1, 0, 0);
    cyc(1, 32'h6, 0);
    lit("mis", 32'h4, 0, 1, 1);
    cyc(0, 32'h0, 0);
    lit("mis_hold", 32'h4, 0, 1, 1);
    rst_pulse();
    lit("mis_rst", 32'h0, 0, 0, 0);

    // randomized run with occasional asynchronous resets
    repeat (3000) begin
      if ((m_halted && $urandom_range(0, 3) == 0) || $urandom_range(0, 299) == 0) begin
        rst_pulse();
      end else begin
        r = $urandom_range(0, 15);
        if (r == 0)      imm = 32'h0;
        else if (r == 1) imm = ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(1, 3));
        else if (r == 2) imm = $urandom & 32'hFFFF_FFFC;
        else             imm = 32'($urandom_range(0, 128)) * 32'd4 - 32'd256;
        cyc($urandom_range(0, 3) == 0, imm, $urandom_range(0, 3) == 0);
      end
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, giving the width of the PC and the immediate.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, giving the PC value loaded at reset.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port PCsrc, input, 1 bit: branch taken for the instruction at the current PC, from the control unit.
REQ-006 SHALL have port ImmOp, input, DATA_WIDTH bits: sign-extended branch offset for the instruction at the current PC.
REQ-007 SHALL have port stall, input, 1 bit: downstream not ready; hold the current PC.
REQ-008 SHALL have port PC, output, DATA_WIDTH bits: current fetch address, driven to instruction memory and control decode.
REQ-009 SHALL have port pc_valid, output, 1 bit: PC holds a real instruction slot this cycle (low means bubble).
REQ-010 SHALL have port halted, output, 1 bit: fetch stopped by self-branch or misaligned target.
REQ-011 SHALL have port misaligned, output, 1 bit: sticky flag; the last taken branch target had bits [1:0] not equal to 0.

Function
REQ-012 SHALL implement the states BOOT, RUN, BUBBLE and HALT, held in a registered state variable.
REQ-013 SHALL, in BOOT, hold PC=RESET_PC with pc_valid=0 for exactly one cycle, then go to RUN.
REQ-014 SHALL, in RUN with stall=1, hold PC and state and drive pc_valid=1; PCsrc is ignored that cycle because stall has priority.
REQ-015 SHALL, in RUN with stall=0 and PCsrc=0, update PC to PC+4 (modulo 2^DATA_WIDTH) and stay in RUN.
REQ-016 SHALL, in RUN with stall=0 and PCsrc=1, compute target = PC+ImmOp (modulo 2^DATA_WIDTH, ImmOp treated as two's complement).
REQ-017 SHALL, when target[1:0] is not 0, hold PC, set misaligned=1 and go to HALT.
REQ-018 SHALL, when ImmOp is 0 (branch to self), hold PC and go to HALT with misaligned unchanged.
REQ-019 SHALL, for any other taken branch, load PC=target and go to BUBBLE.
REQ-020 SHALL, in BUBBLE, hold PC, drive pc_valid=0 for one cycle, then go to RUN, ignoring stall and PCsrc.
REQ-021 SHALL, in HALT, hold PC, drive pc_valid=0 and halted=1, and leave HALT only through reset.
REQ-022 SHALL wrap PC+4 from 32'hFFFF_FFFC to 32'h0000_0000 with no flag raised.
REQ-023 SHALL drive PC, pc_valid, halted and misaligned directly from registers or state decode only, with no combinational path from any input.

Reset
REQ-024 SHALL, while rst_n=0, immediately force state=BOOT, PC=RESET_PC, pc_valid=0, halted=0 and misaligned=0, independent of clk.
REQ-025 SHALL, on an assertion of rst_n in any state (including mid-BUBBLE or HALT), abandon the pending branch and restart from BOOT.
REQ-026 SHALL resume on the first rising clk edge after rst_n deasserts, with BOOT lasting one cycle from that edge.

Configuration
REQ-027 SHALL, when macro PC_FETCH_BRANCH_COUNT_EN is defined, add output branch_count (32 bits), counting taken branches loaded per REQ-019; it resets to 0 and wraps at 2^32.
REQ-028 SHALL, without PC_FETCH_BRANCH_COUNT_EN, have neither the branch_count port nor its counter, with all other behaviour identical.

Verification
REQ-029 SHALL cover reset release, PCsrc=0 and stall=0: cycle 0 PC=0 with pc_valid=0, then PC=0, 4, 8, 12 with pc_valid=1.
REQ-030 SHALL cover, at PC=8, PCsrc=1 with ImmOp=32'hFFFF_FFF8: next PC=0 with pc_valid=0 for one cycle, then PC=4; branch_count=1 when enabled.
REQ-031 SHALL cover, at PC=16, stall=1 for 3 cycles with PCsrc=1 and ImmOp=8: PC holds at 16 for 3 cycles, then PC=24 followed by a bubble.
REQ-032 SHALL cover, at PC=12, PCsrc=1 with ImmOp=0: PC holds at 12, halted=1 and pc_valid=0 indefinitely; rst_n pulse yields PC=0 and halted=0.
REQ-033 SHALL cover, at PC=4, PCsrc=1 with ImmOp=6: misaligned=1, halted=1 and PC remains 4.
REQ-034 SHALL cover RESET_PC=32'hFFFF_FFF8 with a free run: PC steps FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
